multi_port_inorder_queue: RTL and testbench
===========================================

# multi_port_inorder_queue

Parametrised, multi-ported successor to the single-entry in-order instruction queue between decode and the out-of-order hardware. Each cycle it accepts up to ENQ_PORTS entries from decode and releases up to DEQ_PORTS entries, oldest first. It exposes exact occupancy, uses every slot (true full at 2**INDEX_BITS), supports a pipeline flush, and has a head-relative peek port. The queue stays a circular buffer with head/tail pointers, widened to multi-entry moves.

## Interface
- WIDTH, 302: bits per entry.
- INDEX_BITS, 4: pointer width; DEPTH = 2**INDEX_BITS entries.
- ENQ_PORTS, 4: maximum entries enqueued per cycle (1..DEPTH).
- DEQ_PORTS, 4: maximum entries dequeued per cycle (1..DEPTH).
- Derived: ECB = $clog2(ENQ_PORTS+1), DCB = $clog2(DEQ_PORTS+1), CB = INDEX_BITS+1.

Ports:
- clock_i  in  1  clock; all state changes on its rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous discard of all contents.
- enqCount_i  in  ECB  number of valid enqueue slots this cycle; values above ENQ_PORTS are clamped to ENQ_PORTS.
- enqEntries_i  in  ENQ_PORTS*WIDTH  slot k at bits k*WIDTH +: WIDTH; slot 0 is oldest.
- enqAck_o  out  1  registered; high one cycle after a request was accepted.
- deqCount_i  in  DCB  number of entries requested this cycle.
- deqEntries_o  out  DEQ_PORTS*WIDTH  registered dequeued entries; slot 0 is oldest.
- deqValid_o  out  DEQ_PORTS  registered; bit k set when slot k holds data.
- peekEnable_i  in  1  peek request.
- peekOffset_i  in  INDEX_BITS  offset from head.
- peekEntry_o  out  WIDTH  registered entry at head+offset.
- peekValid_o  out  1  registered; high when offset < count at request time.
- count_o  out  CB  occupancy.
- freeSlots_o  out  CB  DEPTH - count.
- empty_o, full_o  out  1 each  count==0 and count==DEPTH.
- head_o, tail_o  out  INDEX_BITS each  current pointers.

## Operation
- State: storage array, head, tail, count (CB bits). count is authoritative; empty and full are derived from it, never from pointer equality.
- Enqueue is all-or-nothing:
  - Accepted iff enqCount_i != 0 and enqCount_i <= freeSlots at start of cycle.
  - On accept: slots 0..n-1 are written to tail..tail+n-1 mod DEPTH, tail += n mod DEPTH.
  - A rejected request writes nothing, and enqAck_o stays low. Decode must hold its request until acked.
- Dequeue grants g = min(deqCount_i, count at start of cycle):
  - Entries head..head+g-1 go to deqEntries_o slots 0..g-1, deqValid_o = (1<<g)-1, head += g mod DEPTH.
  - Ungranted slots keep their old data with valid bits cleared.
- Same-cycle enqueue and dequeue:
  - Both decisions use start-of-cycle count and pointers. A same-cycle dequeue does not free space for the same-cycle enqueue, and a same-cycle enqueue cannot be dequeued in that cycle.
  - New count = count + accepted - g.
- Peek uses start-of-cycle contents and reads storage[(head+peekOffset_i) mod DEPTH]. peekValid_o is low when peekEnable_i is low.
- Flush has priority over enqueue and dequeue in the same cycle:
  - head, tail and count go to 0; enqAck_o, deqValid_o and peekValid_o go to 0.
  - Storage contents need not be cleared.
- Reset (asynchronous on resetn_i low, held while low):
  - head_o, tail_o, count_o = 0; freeSlots_o = DEPTH; empty_o = 1; full_o = 0.
  - enqAck_o, deqValid_o, peekValid_o = 0; deqEntries_o and peekEntry_o = 0.
  - A reset mid-operation discards all entries, and any pending request is lost.
- Wrap-around: all pointer arithmetic is modulo DEPTH, and a multi-entry write or read may straddle index DEPTH-1 -> 0.

## Timing
- Enqueue to enqAck_o: 1 cycle. An entry written at edge N is dequeueable by a request presented in the cycle after edge N.
- Dequeue request to deqEntries_o/deqValid_o: 1 cycle.
- Peek: 1 cycle.
- count_o, freeSlots_o, empty_o, full_o, head_o, tail_o: registered, updated on the same edge as the state they describe.
- Full throughput: ENQ_PORTS in and DEQ_PORTS out per cycle, with no bubbles.

## Test plan
- Reset, then enqueue 4 (A0..A3) -> next cycle: enqAck_o=1, count_o=4, tail_o=4, empty_o=0.
- Request 3 with count=4 -> deqValid_o=0b0111 holding A0,A1,A2; count_o=1, head_o=3. Then request 4 -> deqValid_o=0b0001 holding A3, empty_o=1.
- DEPTH=16: fill to 14, then enqueue 4 -> rejected (enqAck_o=0, count stays 14). Enqueue 2 -> count_o=16, full_o=1, freeSlots_o=0.
- Wrap: with head=14, tail=14, count=0, enqueue 4 -> tail_o=2. Then dequeue 4 -> entries returned in order from indices 14,15,0,1.
- Simultaneous enqueue 4 and dequeue 4 at count=14 -> enqueue rejected, 4 dequeued, count_o=10. Same stimulus with flush_i=1 -> count_o=0, deqValid_o=0, enqAck_o=0.
- Drop resetn_i mid-burst with count=9 -> outputs take reset values immediately, without waiting for a clock edge. After release, peek offset 0 -> peekValid_o=0.

Source files
------------

// File: rtl/multi_port_inorder_queue.sv
// Multi-ported in-order circular queue between decode and the OoO backend.
// All-or-nothing enqueue of up to ENQ_PORTS entries; dequeue of up to DEQ_PORTS, oldest first.
module multi_port_inorder_queue #(
  parameter int WIDTH      = 302,
  parameter int INDEX_BITS = 4,
  parameter int ENQ_PORTS  = 4,
  parameter int DEQ_PORTS  = 4,
  localparam int DEPTH = 2**INDEX_BITS,
  localparam int ECB   = $clog2(ENQ_PORTS+1),
  localparam int DCB   = $clog2(DEQ_PORTS+1),
  localparam int CB    = INDEX_BITS+1
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic                       flush_i,
  input  logic [ECB-1:0]             enqCount_i,
  input  logic [ENQ_PORTS*WIDTH-1:0] enqEntries_i,
  output logic                       enqAck_o,
  input  logic [DCB-1:0]             deqCount_i,
  output logic [DEQ_PORTS*WIDTH-1:0] deqEntries_o,
  output logic [DEQ_PORTS-1:0]       deqValid_o,
  input  logic                       peekEnable_i,
  input  logic [INDEX_BITS-1:0]      peekOffset_i,
  output logic [WIDTH-1:0]           peekEntry_o,
  output logic                       peekValid_o,
  output logic [CB-1:0]              count_o,
  output logic [CB-1:0]              freeSlots_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [INDEX_BITS-1:0]      head_o,
  output logic [INDEX_BITS-1:0]      tail_o
);

  logic [DEPTH-1:0][WIDTH-1:0]     mem_q;
  logic [INDEX_BITS-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CB-1:0]                   count_q, count_d;
  logic [CB-1:0]                   free, enq_n, enq_acc, deq_n, deq_g;
  logic                            enq_ok;
  logic                            ack_q;
  logic [DEQ_PORTS-1:0][WIDTH-1:0] deq_data_q;
  logic [DEQ_PORTS-1:0]            deq_vld_q;
  logic [WIDTH-1:0]                peek_q;
  logic                            peek_vld_q;

  // Decisions use start-of-cycle occupancy only; a same-cycle dequeue frees nothing.
  always_comb begin
    free    = CB'(DEPTH) - count_q;
    enq_n   = (enqCount_i > ECB'(ENQ_PORTS)) ? CB'(ENQ_PORTS) : CB'(enqCount_i);
    enq_ok  = (enq_n != '0) && (enq_n <= free);
    enq_acc = enq_ok ? enq_n : '0;
    deq_n   = (deqCount_i > DCB'(DEQ_PORTS)) ? CB'(DEQ_PORTS) : CB'(deqCount_i);
    deq_g   = (deq_n < count_q) ? deq_n : count_q;
    head_d  = head_q + INDEX_BITS'(deq_g);
    tail_d  = tail_q + INDEX_BITS'(enq_acc);
    count_d = count_q + enq_acc - deq_g;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      deq_vld_q  <= '0;
      deq_data_q <= '0;
      peek_vld_q <= 1'b0;
      peek_q     <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ack_q   <= enq_ok && !flush_i;
      for (int k = 0; k < DEQ_PORTS; k++) begin
        deq_vld_q[k] <= !flush_i && (CB'(k) < deq_g);
        // ungranted slots hold their previous data
        if (!flush_i && (CB'(k) < deq_g))
          deq_data_q[k] <= mem_q[head_q + INDEX_BITS'(k)];
      end
      peek_vld_q <= peekEnable_i && !flush_i && (CB'(peekOffset_i) < count_q);
      if (peekEnable_i)
        peek_q <= mem_q[head_q + peekOffset_i];
    end
  end

  always_ff @(posedge clock_i) begin
    for (int k = 0; k < ENQ_PORTS; k++)
      if (!flush_i && enq_ok && (CB'(k) < enq_n))
        mem_q[tail_q + INDEX_BITS'(k)] <= enqEntries_i[k*WIDTH +: WIDTH];
  end

  assign enqAck_o     = ack_q;
  assign deqEntries_o = deq_data_q;
  assign deqValid_o   = deq_vld_q;
  assign peekEntry_o  = peek_q;
  assign peekValid_o  = peek_vld_q;
  assign count_o      = count_q;
  assign freeSlots_o  = free;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CB'(DEPTH));
  assign head_o       = head_q;
  assign tail_o       = tail_q;

endmodule

// File: tb/tb_multi_port_inorder_queue.sv
// Directed bench for multi_port_inorder_queue with hand-computed expectations.
module tb_multi_port_inorder_queue;
  localparam int W   = 302;
  localparam int IB  = 4;
  localparam int EP  = 4;
  localparam int DP  = 4;
  localparam int ECB = $clog2(EP+1);
  localparam int DCB = $clog2(DP+1);
  localparam int CB  = IB+1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [ECB-1:0]    enq_cnt = '0;
  logic [EP*W-1:0]   enq_ent = '0;
  logic              ack;
  logic [DCB-1:0]    deq_cnt = '0;
  logic [DP*W-1:0]   deq_ent;
  logic [DP-1:0]     deq_vld;
  logic              pk_en = 1'b0;
  logic [IB-1:0]     pk_off = '0;
  logic [W-1:0]      pk_ent;
  logic              pk_vld;
  logic [CB-1:0]     count, free;
  logic              empty, full;
  logic [IB-1:0]     head, tail;

  int errs = 0;
  int checks = 0;

  multi_port_inorder_queue #(.WIDTH(W), .INDEX_BITS(IB), .ENQ_PORTS(EP), .DEQ_PORTS(DP)) dut (
    .clock_i(clk), .resetn_i(rst_n), .flush_i(flush),
    .enqCount_i(enq_cnt), .enqEntries_i(enq_ent), .enqAck_o(ack),
    .deqCount_i(deq_cnt), .deqEntries_o(deq_ent), .deqValid_o(deq_vld),
    .peekEnable_i(pk_en), .peekOffset_i(pk_off), .peekEntry_o(pk_ent), .peekValid_o(pk_vld),
    .count_o(count), .freeSlots_o(free), .empty_o(empty), .full_o(full),
    .head_o(head), .tail_o(tail)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] val(input int v);
    logic [319:0] t;
    t = {10{v}};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] slot(input int k);
    return deq_ent[k*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock with the given enqueue/dequeue request; returns 1ns after the edge
  task automatic cyc(input int en, input int eb, input int dn);
    enq_cnt = ECB'(en);
    for (int k = 0; k < EP; k++) enq_ent[k*W +: W] = val(eb + k);
    deq_cnt = DCB'(dn);
    @(posedge clk); #1;
    enq_cnt = '0;
    deq_cnt = '0;
  endtask

  initial begin
    #3;
    chk("rst_count", W'(count), W'(0));
    chk("rst_free",  W'(free),  W'(16));
    chk("rst_empty", W'(empty), W'(1));
    chk("rst_full",  W'(full),  W'(0));
    chk("rst_head",  W'(head),  W'(0));
    chk("rst_tail",  W'(tail),  W'(0));
    chk("rst_ack",   W'(ack),   W'(0));
    chk("rst_dvld",  W'(deq_vld), W'(0));
    chk("rst_pvld",  W'(pk_vld),  W'(0));
    chk("rst_dent0", slot(0), W'(0));
    chk("rst_pent",  pk_ent,  W'(0));
    #9 rst_n = 1'b1;

    cyc(4, 'hA0, 0);
    chk("enq4_ack",   W'(ack),   W'(1));
    chk("enq4_count", W'(count), W'(4));
    chk("enq4_tail",  W'(tail),  W'(4));
    chk("enq4_empty", W'(empty), W'(0));

    cyc(0, 0, 3);
    chk("deq3_vld",   W'(deq_vld), W'(4'b0111));
    chk("deq3_s0",    slot(0), val('hA0));
    chk("deq3_s1",    slot(1), val('hA1));
    chk("deq3_s2",    slot(2), val('hA2));
    chk("deq3_count", W'(count), W'(1));
    chk("deq3_head",  W'(head),  W'(3));
    cyc(0, 0, 4);
    chk("deq4_vld",   W'(deq_vld), W'(4'b0001));
    chk("deq4_s0",    slot(0), val('hA3));
    chk("deq4_hold1", slot(1), val('hA1));
    chk("deq4_empty", W'(empty), W'(1));
    chk("deq4_head",  W'(head),  W'(4));

    cyc(4, 'hB0, 0); cyc(4, 'hB4, 0); cyc(4, 'hB8, 0); cyc(2, 'hBC, 0);
    chk("fill14_count", W'(count), W'(14));
    cyc(4, 'hE0, 0);
    chk("rej_ack",   W'(ack),   W'(0));
    chk("rej_count", W'(count), W'(14));
    cyc(2, 'hC0, 0);
    chk("full_ack",   W'(ack),   W'(1));
    chk("full_count", W'(count), W'(16));
    chk("full_full",  W'(full),  W'(1));
    chk("full_free",  W'(free),  W'(0));
    chk("full_tail",  W'(tail),  W'(4));

    pk_en = 1'b1; pk_off = IB'(5);
    @(posedge clk); #1;
    chk("peek5_vld", W'(pk_vld), W'(1));
    chk("peek5_ent", pk_ent, val('hB5));
    pk_off = IB'(15);
    @(posedge clk); #1;
    chk("peek15_vld", W'(pk_vld), W'(1));
    chk("peek15_ent", pk_ent, val('hC1));
    pk_en = 1'b0;
    @(posedge clk); #1;
    chk("peek_off_vld", W'(pk_vld), W'(0));

    cyc(0, 0, 2);
    chk("d2_count", W'(count), W'(14));
    chk("d2_head",  W'(head),  W'(6));
    cyc(4, 'hF0, 4);
    chk("sim_ack",   W'(ack),   W'(0));
    chk("sim_vld",   W'(deq_vld), W'(4'b1111));
    chk("sim_s0",    slot(0), val('hB2));
    chk("sim_s3",    slot(3), val('hB5));
    chk("sim_count", W'(count), W'(10));
    flush = 1'b1;
    cyc(4, 'hF0, 4);
    flush = 1'b0;
    chk("fl_count", W'(count), W'(0));
    chk("fl_vld",   W'(deq_vld), W'(0));
    chk("fl_ack",   W'(ack),   W'(0));
    chk("fl_head",  W'(head),  W'(0));
    chk("fl_tail",  W'(tail),  W'(0));

    cyc(7, 'h10, 0);
    chk("clamp_ack",   W'(ack),   W'(1));
    chk("clamp_count", W'(count), W'(4));
    cyc(4, 'h20, 4);
    chk("tput_ack",   W'(ack),   W'(1));
    chk("tput_vld",   W'(deq_vld), W'(4'b1111));
    chk("tput_s0",    slot(0), val('h10));
    chk("tput_s3",    slot(3), val('h13));
    chk("tput_count", W'(count), W'(4));
    chk("tput_tail",  W'(tail),  W'(8));

    cyc(4, 'h30, 0); cyc(2, 'h34, 0);
    cyc(0, 0, 4); cyc(0, 0, 4); cyc(0, 0, 2);
    chk("pre_wrap_head",  W'(head),  W'(14));
    chk("pre_wrap_tail",  W'(tail),  W'(14));
    chk("pre_wrap_count", W'(count), W'(0));
    cyc(4, 'h40, 0);
    chk("wrap_tail", W'(tail), W'(2));
    cyc(0, 0, 4);
    chk("wrap_vld",  W'(deq_vld), W'(4'b1111));
    chk("wrap_s0",   slot(0), val('h40));
    chk("wrap_s1",   slot(1), val('h41));
    chk("wrap_s2",   slot(2), val('h42));
    chk("wrap_s3",   slot(3), val('h43));
    chk("wrap_head", W'(head), W'(2));

    cyc(4, 'h50, 0); cyc(4, 'h54, 0); cyc(1, 'h58, 0);
    chk("burst_count", W'(count), W'(9));
    enq_cnt = ECB'(4);
    for (int k = 0; k < EP; k++) enq_ent[k*W +: W] = val('h60 + k);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", W'(count), W'(0));
    chk("arst_tail",  W'(tail),  W'(0));
    chk("arst_head",  W'(head),  W'(0));
    chk("arst_empty", W'(empty), W'(1));
    chk("arst_free",  W'(free),  W'(16));
    chk("arst_dent0", slot(0), W'(0));
    rst_n = 1'b1;
    enq_cnt = '0;
    pk_en = 1'b1; pk_off = '0;
    @(posedge clk); #1;
    chk("post_pvld",  W'(pk_vld), W'(0));
    chk("post_count", W'(count),  W'(0));
    pk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
